// File: rtl/dac_ctrl_pkg.sv
// Shared types and constants for the thermometer DAC sweep sequencer.
// Mode 2'b11 is reserved and folds onto UP when it is latched.
package dac_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_TRI  = 2'b10;

   localparam int DEF_N_BITS = 4;
   localparam int DEF_HOLD_W = 4;

   function automatic logic [1:0] norm_mode(input logic [1:0] i_mode);
      return (i_mode == 2'b11) ? MODE_UP : i_mode;
   endfunction

endpackage

// File: rtl/therm_enc.sv
// Level to thermometer encoder: the lowest i_level bits of o_code are set.
// Purely combinational.
module therm_enc
   import dac_ctrl_pkg::*;
#(
   parameter int N_BITS = DEF_N_BITS,
   parameter int LVL_W  = $clog2(N_BITS + 1)
) (
   input  logic [LVL_W-1:0]  i_level,
   output logic [N_BITS-1:0] o_code
);

   logic [31:0] w_lvl;

   assign w_lvl = 32'(i_level);

   always_comb begin
      o_code = '0;
      for (int k = 0; k < N_BITS; k++) begin
         o_code[k] = (k < w_lvl);
      end
   end

endmodule

// File: rtl/dac_seq_ctrl.sv
// Start/busy/done sweep sequencer driving a thermometer-coded DAC through
// UP, DOWN or TRI ramps, holding each code for a programmable number of cycles.
module dac_seq_ctrl
   import dac_ctrl_pkg::*;
#(
   parameter int N_BITS = DEF_N_BITS,
   parameter int HOLD_W = DEF_HOLD_W
) (
   input  logic                         dac_clk,
   input  logic                         dac_rst,
   input  logic                         start,
   input  logic                         abort,
   input  logic [1:0]                   cfg_mode,
   input  logic [HOLD_W-1:0]            cfg_hold,
   input  logic                         cfg_loop,
   output logic [N_BITS-1:0]            b,
   output logic [$clog2(N_BITS+1)-1:0]  level,
   output logic                         busy,
   output logic                         sample,
   output logic                         done
);

   localparam int LVL_W = $clog2(N_BITS + 1);
   localparam logic [LVL_W-1:0]  LVL_TOP  = LVL_W'(N_BITS);
   localparam logic [LVL_W-1:0]  LVL_PEAK = LVL_W'(N_BITS - 1);
   localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   state_t              r_state;
   logic [LVL_W-1:0]    r_level;
   logic                r_dir;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic [1:0]          r_mode;
   logic [HOLD_W-1:0]   r_hold;
   logic                r_loop;
   logic                r_busy;
   logic                r_sample;
   logic                r_done;

   logic                w_final;
   logic [LVL_W-1:0]    w_step_level;
   logic                w_step_dir;
   logic [LVL_W-1:0]    w_wrap_level;
   logic                w_wrap_dir;
   logic [1:0]          w_start_mode;

   assign w_start_mode = norm_mode(cfg_mode);

   // Next code within a sweep, and the restart point when looping.
   always_comb begin
      w_final      = 1'b0;
      w_step_level = r_level;
      w_step_dir   = r_dir;
      w_wrap_level = '0;
      w_wrap_dir   = 1'b1;
      case (r_mode)
         MODE_DOWN: begin
            w_final      = (r_level == '0);
            w_step_level = r_level - LVL_ONE;
            w_wrap_level = LVL_TOP;
            w_wrap_dir   = 1'b0;
         end
         MODE_TRI: begin
            w_final      = !r_dir && (r_level == '0);
            w_wrap_level = LVL_ONE;
            if (r_dir && (r_level == LVL_TOP)) begin
               w_step_level = LVL_PEAK;
               w_step_dir   = 1'b0;
            end else if (r_dir) begin
               w_step_level = r_level + LVL_ONE;
            end else begin
               w_step_level = r_level - LVL_ONE;
            end
         end
         default: begin
            w_final      = (r_level == LVL_TOP);
            w_step_level = r_level + LVL_ONE;
         end
      endcase
   end

   always_ff @(posedge dac_clk or posedge dac_rst) begin
      if (dac_rst) begin
         r_state    <= IDLE;
         r_level    <= '0;
         r_dir      <= 1'b0;
         r_hold_cnt <= '0;
         r_mode     <= '0;
         r_hold     <= '0;
         r_loop     <= 1'b0;
         r_busy     <= 1'b0;
         r_sample   <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_level  <= '0;
               r_busy   <= 1'b0;
               r_sample <= 1'b0;
               r_done   <= 1'b0;
               if (start && !abort) begin
                  r_mode     <= w_start_mode;
                  r_hold     <= cfg_hold;
                  r_loop     <= cfg_loop;
                  r_level    <= (w_start_mode == MODE_DOWN) ? LVL_TOP : '0;
                  r_dir      <= (w_start_mode != MODE_DOWN);
                  r_hold_cnt <= cfg_hold;
                  r_busy     <= 1'b1;
                  r_sample   <= (cfg_hold == '0);
                  r_state    <= HOLD;
               end
            end
            HOLD: begin
               if (abort) begin
                  r_state  <= IDLE;
                  r_level  <= '0;
                  r_busy   <= 1'b0;
                  r_sample <= 1'b0;
                  r_done   <= 1'b0;
               end else if (r_hold_cnt != '0) begin
                  r_hold_cnt <= r_hold_cnt - HOLD_ONE;
                  r_sample   <= (r_hold_cnt == HOLD_ONE);
               end else if (w_final && !r_loop) begin
                  r_state  <= DONE;
                  r_sample <= 1'b0;
                  r_done   <= 1'b1;
               end else begin
                  r_level    <= w_final ? w_wrap_level : w_step_level;
                  r_dir      <= w_final ? w_wrap_dir : w_step_dir;
                  r_hold_cnt <= r_hold;
                  r_sample   <= (r_hold == '0);
               end
            end
            default: begin
               r_state  <= IDLE;
               r_level  <= '0;
               r_busy   <= 1'b0;
               r_sample <= 1'b0;
               r_done   <= 1'b0;
            end
         endcase
      end
   end

   therm_enc #(
      .N_BITS (N_BITS),
      .LVL_W  (LVL_W)
   ) u_enc (
      .i_level (r_level),
      .o_code  (b)
   );

   assign level  = r_level;
   assign busy   = r_busy;
   assign sample = r_sample;
   assign done   = r_done;

endmodule

// File: tb/tb_dac_seq_ctrl.sv
// Bench for dac_seq_ctrl: a 4-bit and an 8-bit instance checked cycle by cycle
// against sweep sequences built from the ramp rules.
module tb_dac_seq_ctrl;

   logic       dac_clk = 1'b0;
   logic       dac_rst;
   logic       start4, start8, abort;
   logic [1:0] cfg_mode;
   logic [3:0] cfg_hold;
   logic       cfg_loop;

   logic [3:0] b4;
   logic [2:0] lvl4;
   logic       busy4, smp4, done4;
   logic [7:0] b8;
   logic [3:0] lvl8;
   logic       busy8, smp8, done8;

   int n_vec = 0;
   int n_err = 0;
   int exp_lvl[$];
   bit exp_smp[$];

   always #5 dac_clk = ~dac_clk;

   dac_seq_ctrl #(.N_BITS(4), .HOLD_W(4)) u_dut4 (
      .dac_clk  (dac_clk),
      .dac_rst  (dac_rst),
      .start    (start4),
      .abort    (abort),
      .cfg_mode (cfg_mode),
      .cfg_hold (cfg_hold),
      .cfg_loop (cfg_loop),
      .b        (b4),
      .level    (lvl4),
      .busy     (busy4),
      .sample   (smp4),
      .done     (done4)
   );

   dac_seq_ctrl #(.N_BITS(8), .HOLD_W(4)) u_dut8 (
      .dac_clk  (dac_clk),
      .dac_rst  (dac_rst),
      .start    (start8),
      .abort    (abort),
      .cfg_mode (cfg_mode),
      .cfg_hold (cfg_hold),
      .cfg_loop (cfg_loop),
      .b        (b8),
      .level    (lvl8),
      .busy     (busy8),
      .sample   (smp8),
      .done     (done8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge dac_clk);
      #1;
   endtask

   function automatic logic [31:0] o_b(input bit sel);
      return sel ? 32'(b8) : 32'(b4);
   endfunction
   function automatic logic [31:0] o_lvl(input bit sel);
      return sel ? 32'(lvl8) : 32'(lvl4);
   endfunction
   function automatic logic [31:0] o_busy(input bit sel);
      return sel ? 32'(busy8) : 32'(busy4);
   endfunction
   function automatic logic [31:0] o_smp(input bit sel);
      return sel ? 32'(smp8) : 32'(smp4);
   endfunction
   function automatic logic [31:0] o_done(input bit sel);
      return sel ? 32'(done8) : 32'(done4);
   endfunction

   task automatic chk_idle(input bit sel, input string tag);
      chk({tag, ".busy"},   o_busy(sel), 0);
      chk({tag, ".b"},      o_b(sel),    0);
      chk({tag, ".level"},  o_lvl(sel),  0);
      chk({tag, ".sample"}, o_smp(sel),  0);
      chk({tag, ".done"},   o_done(sel), 0);
   endtask

   // Expected per-cycle level/sample stream: the ramp as a list of levels,
   // each repeated hold+1 times with sample on the last repetition.
   task automatic build(input int mode, input int hold, input int n, input bit loop,
                        input int min_len);
      int lv[$];
      int pass;
      pass = 0;
      exp_lvl.delete();
      exp_smp.delete();
      do begin
         lv.delete();
         if (mode == 1) begin
            for (int l = n; l >= 0; l--) lv.push_back(l);
         end else if (mode == 2) begin
            for (int l = (pass > 0) ? 1 : 0; l <= n; l++) lv.push_back(l);
            for (int l = n - 1; l >= 0; l--) lv.push_back(l);
         end else begin
            for (int l = 0; l <= n; l++) lv.push_back(l);
         end
         foreach (lv[j]) begin
            for (int h = 0; h <= hold; h++) begin
               exp_lvl.push_back(lv[j]);
               exp_smp.push_back(h == hold);
            end
         end
         pass++;
      end while (loop && exp_lvl.size() < min_len);
   endtask

   task automatic run_sweep(input bit sel, input int mode, input int hold, input bit loop,
                            input int abort_at, input bit noise);
      int n;
      int steps;
      int fl;
      bit aborted;
      n = sel ? 8 : 4;
      aborted = 1'b0;
      build(mode, hold, n, loop, abort_at + 1);
      cfg_mode = mode[1:0];
      cfg_hold = hold[3:0];
      cfg_loop = loop;
      if (sel) start8 = 1'b1;
      else     start4 = 1'b1;
      tick();
      start4 = 1'b0;
      start8 = 1'b0;
      steps = exp_lvl.size();
      for (int i = 0; i < steps && !aborted; i++) begin
         chk("sweep.level",  o_lvl(sel),  exp_lvl[i]);
         chk("sweep.b",      o_b(sel),    (32'd1 << exp_lvl[i]) - 32'd1);
         chk("sweep.sample", o_smp(sel),  exp_smp[i]);
         chk("sweep.busy",   o_busy(sel), 1);
         chk("sweep.done",   o_done(sel), 0);
         if (i == abort_at) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk_idle(sel, "abort");
            aborted = 1'b1;
         end else begin
            if (noise) begin
               if (sel) start8 = 1'($urandom_range(0, 1));
               else     start4 = 1'($urandom_range(0, 1));
               cfg_mode = 2'($urandom_range(0, 3));
               cfg_hold = 4'($urandom_range(0, 15));
               cfg_loop = 1'($urandom_range(0, 1));
            end
            tick();
         end
      end
      start4 = 1'b0;
      start8 = 1'b0;
      if (!aborted && loop) begin
         abort = 1'b1;
         tick();
         abort = 1'b0;
         chk_idle(sel, "loopend");
      end else if (!aborted) begin
         fl = exp_lvl[steps-1];
         chk("done.done",   o_done(sel), 1);
         chk("done.busy",   o_busy(sel), 1);
         chk("done.sample", o_smp(sel),  0);
         chk("done.level",  o_lvl(sel),  fl);
         chk("done.b",      o_b(sel),    (32'd1 << fl) - 32'd1);
         tick();
         chk_idle(sel, "post");
         tick();
         chk_idle(sel, "post2");
      end
   endtask

   initial begin
      int mode, hold, abort_at;
      bit loop, sel, noise;
      dac_rst  = 1'b1;
      start4   = 1'b0;
      start8   = 1'b0;
      abort    = 1'b0;
      cfg_mode = 2'b00;
      cfg_hold = 4'd0;
      cfg_loop = 1'b0;
      tick();
      chk_idle(0, "rst4");
      chk_idle(1, "rst8");
      @(negedge dac_clk);
      dac_rst = 1'b0;
      tick();
      chk_idle(0, "rel4");

      run_sweep(0, 0, 0, 0, -1, 0);
      run_sweep(0, 1, 2, 0, -1, 0);
      run_sweep(0, 2, 0, 1, 19, 0);
      run_sweep(0, 0, 0, 0, -1, 1);

      start4 = 1'b1;
      abort  = 1'b1;
      tick();
      start4 = 1'b0;
      abort  = 1'b0;
      chk_idle(0, "startabort");
      tick();
      chk_idle(0, "startabort2");

      cfg_mode = 2'b00;
      cfg_hold = 4'd3;
      cfg_loop = 1'b0;
      start4   = 1'b1;
      tick();
      start4 = 1'b0;
      tick();
      chk("arst.pre_busy", o_busy(0), 1);
      #3;
      dac_rst = 1'b1;
      #1;
      chk_idle(0, "arst");
      @(negedge dac_clk);
      dac_rst = 1'b0;
      run_sweep(0, 0, 1, 0, -1, 0);

      run_sweep(0, 3, 0, 0, -1, 0);
      run_sweep(1, 3, 0, 0, -1, 0);

      repeat (40) begin
         mode  = $urandom_range(0, 3);
         hold  = $urandom_range(0, 3);
         loop  = 1'($urandom_range(0, 1));
         sel   = ($urandom_range(0, 4) == 0);
         noise = 1'($urandom_range(0, 1));
         if (loop) abort_at = $urandom_range(0, 45);
         else      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
         run_sweep(sel, mode, hold, loop, abort_at, noise);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
